// File: rtl/host_wb_master_pkg.sv
// host_wb_master_pkg: opcodes, status bytes and FSM encoding shared by host_wb_master.
package host_wb_master_pkg;
  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] ST_OK      = 8'h06;
  localparam logic [7:0] ST_ERR     = 8'h15;
  localparam logic [7:0] ST_BADOP   = 8'h3F;
  localparam logic [7:0] ST_TIMEOUT = 8'h54;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_WAIT,
    S_RSP_STAT,
    S_RSP_DATA
  } state_t;
endpackage

// File: rtl/host_wb_master.sv
// host_wb_master: byte-stream command engine mastering a pipelined Wishbone slave port.
// Defining WB_TIMEOUT_EN adds a bus watchdog that answers 0x54 after TIMEOUT_CYCLES.
module host_wb_master
  import host_wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic [7:0]            TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  CYC,
  output logic                  STB,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  SEL,
  input  logic                  STALL,
  input  logic                  ACK,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  ERR,
  output logic                  BUSY
);
  localparam int NB = ADDR_WIDTH / 8;
  if (ADDR_WIDTH % 8 != 0 || DATA_WIDTH != 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("host_wb_master: unsupported parameter set");
  end
  state_t state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]            tx_q, tx_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rx_fire, bus_done, tmo_hit, rd_ok;
  assign rx_fire  = RX_VALID && RX_READY;
  assign bus_done = (state_q == S_WAIT || (state_q == S_REQ && !STALL)) && (ACK || ERR);
  // only a successful read leaves ST_OK pending with WE clear
  assign rd_ok    = !we_q && tx_q == ST_OK;
`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_q, tmo_d;
  always_comb tmo_d = (state_q == S_REQ || state_q == S_WAIT) ? tmo_q + 1'b1 : '0;
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) state_q <= S_IDLE;
    else state_q <= state_d;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      tx_q   <= '0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      tx_q   <= tx_d;
      cnt_q  <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:
        if (rx_fire) begin
          if (RX_DATA == OP_WRITE || RX_DATA == OP_READ) begin
            we_d    = RX_DATA == OP_WRITE;
            cnt_d   = '0;
            state_d = S_ADDR;
          end else begin
            tx_d    = ST_BADOP;
            state_d = S_RSP_STAT;
          end
        end
      S_ADDR:
        if (rx_fire) begin
          addr_d = ADDR_WIDTH'({addr_q, RX_DATA});
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == 8'(NB - 1)) state_d = we_q ? S_DATA : S_REQ;
        end
      S_DATA:
        if (rx_fire) begin
          data_d  = RX_DATA;
          state_d = S_REQ;
        end
      S_REQ, S_WAIT:
        if (bus_done) begin
          tx_d    = ERR ? ST_ERR : ST_OK;
          data_d  = (!ERR && !we_q) ? RDATA : data_q;
          state_d = S_RSP_STAT;
        end else if (tmo_hit) begin
          tx_d    = ST_TIMEOUT;
          state_d = S_RSP_STAT;
        end else if (state_q == S_REQ && !STALL) begin
          state_d = S_WAIT;
        end
      S_RSP_STAT:
        if (TX_READY) begin
          tx_d    = rd_ok ? data_q : tx_q;
          state_d = rd_ok ? S_RSP_DATA : S_IDLE;
        end
      S_RSP_DATA:
        if (TX_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    RX_READY = !RST && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
    TX_VALID = state_q == S_RSP_STAT || state_q == S_RSP_DATA;
    TX_DATA  = tx_q;
    CYC      = state_q == S_REQ || state_q == S_WAIT;
    STB      = state_q == S_REQ;
    SEL      = state_q == S_REQ;
    WE       = (state_q == S_REQ || state_q == S_WAIT) && we_q;
    ADDR     = addr_q;
    WDATA    = data_q;
    BUSY     = state_q != S_IDLE;
  end
endmodule

// File: tb/tb_host_wb_master.sv
// tb_host_wb_master: randomized command traffic against a byte-level response model.
module tb_host_wb_master;
  localparam int TMO = 255;
  logic        CLK = 1'b0;
  logic        RST, RX_VALID, RX_READY, TX_VALID, TX_READY;
  logic [7:0]  RX_DATA, TX_DATA, WDATA, RDATA;
  logic        CYC, STB, WE, SEL, STALL, ACK, ERR, BUSY;
  logic [31:0] ADDR;
  int total = 0;
  int bad = 0;
  host_wb_master dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .CYC(CYC), .STB(STB),
    .WE(WE), .ADDR(ADDR), .WDATA(WDATA), .SEL(SEL), .STALL(STALL), .ACK(ACK),
    .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    while (RX_READY !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (RX_READY !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL rx_accept: byte %h rx_ready=%b, need 1 within 50 cycles", b, RX_READY);
    end
    step();
    RX_VALID = 1'b0;
    RX_DATA  = 8'($urandom);
  endtask
  task automatic start_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8+:8]);
  endtask
  task automatic collect(input int n, input logic [7:0] e0, input logic [7:0] e1, input int hold,
                         input string tag);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      e = k == 0 ? e0 : e1;
      for (int h = 0; h < hold; h++) begin
        ACK = 1'($urandom_range(0, 1));
        ERR = 1'($urandom_range(0, 1));
        total++;
        if (TX_VALID !== 1'b1 || TX_DATA !== e || RX_READY !== 1'b0 || CYC !== 1'b0) begin
          bad++;
          $display("FAIL %s_hold%0d: valid=%b data=%h rx_ready=%b cyc=%b, need 1 %h 0 0",
                   tag, k, TX_VALID, TX_DATA, RX_READY, CYC, e);
        end
        step();
      end
      ACK = 1'b0;
      ERR = 1'b0;
      TX_READY = 1'b1;
      total++;
      if (TX_VALID !== 1'b1 || TX_DATA !== e) begin
        bad++;
        $display("FAIL %s_byte%0d: valid=%b data=%h, need 1 %h", tag, k, TX_VALID, TX_DATA, e);
      end
      step();
      TX_READY = 1'b0;
    end
    total++;
    if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || CYC !== 1'b0) begin
      bad++;
      $display("FAIL %s_end: valid=%b busy=%b cyc=%b, need 0 0 0", tag, TX_VALID, BUSY, CYC);
    end
  endtask
  task automatic do_cmd(input logic [7:0] op, input logic [31:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input int stall_n, input int wait_n, input bit err,
                        input int hold, input string tag);
    bit wr, is_cmd, done;
    int cyc_n, stb_n, acc_n, left, n;
    logic [7:0] e0;
    wr     = op == 8'h57;
    is_cmd = wr || op == 8'h52;
    done   = 1'b0;
    cyc_n  = 0;
    stb_n  = 0;
    acc_n  = 0;
    left   = -1;
    e0     = !is_cmd ? 8'h3F : err ? 8'h15 : 8'h06;
    n      = (is_cmd && !wr && !err) ? 2 : 1;
    send_byte(op);
    if (is_cmd) begin
      for (int i = 3; i >= 0; i--) send_byte(a[i*8+:8]);
      if (wr) send_byte(wd);
      for (int c = 0; c < 100 && !done; c++) begin
        if (CYC === 1'b1) cyc_n++;
        total++;
        if ((STB === 1'b1 && CYC !== 1'b1) || (CYC === 1'b1 && (TX_VALID !== 1'b0 || RX_READY !== 1'b0))) begin
          bad++;
          $display("FAIL %s_hygiene: stb=%b cyc=%b tx_valid=%b rx_ready=%b", tag, STB, CYC, TX_VALID, RX_READY);
        end
        if (STB === 1'b1) begin
          stb_n++;
          total++;
          if (ADDR !== a || WE !== wr || SEL !== 1'b1 || (wr && WDATA !== wd)) begin
            bad++;
            $display("FAIL %s_req: addr=%h we=%b sel=%b wdata=%h, need %h %b 1 %h",
                     tag, ADDR, WE, SEL, WDATA, a, wr, wd);
          end
          STALL = stb_n <= stall_n;
          if (!STALL) begin
            acc_n++;
            left = wait_n;
          end
        end else begin
          STALL = 1'($urandom_range(0, 1));
          if (left > 0) left--;
        end
        if (left == 0) begin
          ERR   = err;
          ACK   = err ? 1'($urandom_range(0, 1)) : 1'b1;
          RDATA = rd;
          done  = 1'b1;
        end
        step();
        ACK   = 1'b0;
        ERR   = 1'b0;
        RDATA = 8'($urandom);
      end
      total++;
      if (!done || CYC !== 1'b0 || STB !== 1'b0 || TX_VALID !== 1'b1) begin
        bad++;
        $display("FAIL %s_complete: done=%b cyc=%b stb=%b tx_valid=%b, need 1 0 0 1",
                 tag, done, CYC, STB, TX_VALID);
      end
      total++;
      if (stb_n != stall_n + 1 || acc_n != 1 || cyc_n != stall_n + 1 + wait_n) begin
        bad++;
        $display("FAIL %s_counts: stb=%0d acc=%0d cyc=%0d, need %0d 1 %0d",
                 tag, stb_n, acc_n, cyc_n, stall_n + 1, stall_n + 1 + wait_n);
      end
    end
    STALL = 1'b0;
    collect(n, e0, rd, hold, tag);
  endtask
  task automatic test_reset;
    RST = 1'b1;
    repeat (2) step();
    total++;
    if ({CYC, STB, WE, SEL, TX_VALID, RX_READY, BUSY} !== 7'b0 || ADDR !== 32'h0 ||
        TX_DATA !== 8'h0 || WDATA !== 8'h0) begin
      bad++;
      $display("FAIL reset_outputs: ctl=%b addr=%h tx=%h wdata=%h, need all zero",
               {CYC, STB, WE, SEL, TX_VALID, RX_READY, BUSY}, ADDR, TX_DATA, WDATA);
    end
    RST = 1'b0;
    step();
    total++;
    if (RX_READY !== 1'b1 || BUSY !== 1'b0 || CYC !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: rx_ready=%b busy=%b cyc=%b, need 1 0 0", RX_READY, BUSY, CYC);
    end
  endtask
  task automatic test_write;
    do_cmd(8'h57, 32'h3000_0010, 8'hA5, 8'h00, 0, 0, 1'b0, 0, "write");
  endtask
  task automatic test_read_wait;
    do_cmd(8'h52, 32'h3000_0010, 8'h00, 8'h5C, 0, 3, 1'b0, 0, "read_wait");
  endtask
  task automatic test_stall;
    do_cmd(8'h57, 32'h3000_0044, 8'h7E, 8'h00, 4, 0, 1'b0, 0, "stall");
  endtask
  task automatic test_error;
    do_cmd(8'h52, 32'h3000_0008, 8'h00, 8'hC3, 0, 1, 1'b1, 1, "error");
  endtask
  task automatic test_badop;
    do_cmd(8'h41, 32'h0, 8'h00, 8'h00, 0, 0, 1'b0, 10, "badop");
  endtask
  task automatic test_back_to_back;
    logic [7:0] op;
    int r;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      op = 8'($urandom);
      if (op == 8'h57 || op == 8'h52) op = 8'h00;
      op = r < 4 ? 8'h57 : r < 8 ? 8'h52 : op;
      do_cmd(op, $urandom, 8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 4) == 0, $urandom_range(0, 3), "rand");
    end
  endtask
  task automatic test_reset_mid;
    start_read(32'h3000_0020);
    STALL = 1'b0;
    repeat (4) step();
    total++;
    if (CYC !== 1'b1 || STB !== 1'b0 || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_wait: cyc=%b stb=%b busy=%b, need 1 0 1", CYC, STB, BUSY);
    end
    #3 RST = 1'b1;
    #1;
    total++;
    if (CYC !== 1'b0 || STB !== 1'b0 || TX_VALID !== 1'b0 || BUSY !== 1'b0 || ADDR !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_async: cyc=%b stb=%b tx_valid=%b busy=%b addr=%h, need 0 0 0 0 0",
               CYC, STB, TX_VALID, BUSY, ADDR);
    end
    step();
    RST = 1'b0;
    repeat (3) step();
    total++;
    if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || RX_READY !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_after: tx_valid=%b busy=%b rx_ready=%b, need 0 0 1", TX_VALID, BUSY, RX_READY);
    end
    do_cmd(8'h57, 32'h1234_ABCD, 8'h3C, 8'h00, 1, 1, 1'b0, 1, "post_reset");
  endtask
  task automatic test_timeout;
    int n = 0;
    start_read(32'h3000_0030);
    STALL = 1'b0;
`ifdef WB_TIMEOUT_EN
    while (CYC === 1'b1 && n < TMO + 100) begin
      step();
      n++;
    end
    total++;
    if (n != TMO) begin
      bad++;
      $display("FAIL timeout_cycles: cyc high %0d cycles, need %0d", n, TMO);
    end
    collect(1, 8'h54, 8'h00, 2, "timeout");
`else
    repeat (TMO + 45) step();
    total++;
    if (CYC !== 1'b1 || TX_VALID !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout: cyc=%b tx_valid=%b, need 1 0", CYC, TX_VALID);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
`endif
  endtask
  initial begin
    RST = 1'b1;
    RX_DATA = 8'h0;
    RX_VALID = 1'b0;
    TX_READY = 1'b0;
    STALL = 1'b0;
    ACK = 1'b0;
    ERR = 1'b0;
    RDATA = 8'h0;
    test_reset();
    test_write();
    test_read_wait();
    test_stall();
    test_error();
    test_badop();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
